rv32i_pc: RTL and testbench

//   Program-counter register for the single-cycle RV32I datapath.
//   - Holds the address of the instruction currently being fetched.
//   - Loads the next-PC value computed upstream on every rising clock edge.
//   - The next-PC value is either PC+4 or a branch/jump target, selected outside this block.
//   - Output drives the instruction-memory address port and the PC+4 / branch-target adders.
//

---
 rtl/rv32i_pc.sv | 22 ++
 tb/tb_rv32i_pc.sv | 101 ++++++++++
 2 files changed

// File: rtl/rv32i_pc.sv
// Program-counter register for the single-cycle RV32I datapath.
// Loads next_pc on every rising edge; synchronous active-high reset wins.
module rv32i_pc #(
  parameter int unsigned         XLEN         = 32,
  parameter logic [XLEN-1:0]     RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc
);

  // No enable and no masking: stalls feed pc back as next_pc, alignment lives upstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else begin
      pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_rv32i_pc.sv
// Directed bench for rv32i_pc: reset priority, one-cycle load latency,
// jumps, mid-run reset, full-width values and stability between edges.
module tb_rv32i_pc;

  localparam int W = 32;

  // clock / reset
  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] next_pc;
  logic [W-1:0] pc;

  always #5 clk = ~clk;

  rv32i_pc #(.XLEN(W), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk     (clk),
    .reset   (reset),
    .next_pc (next_pc),
    .pc      (pc)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_exp;
  int           checks = 0;
  int           errors = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: pc=%h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] npc;
    string        tag;
  } vec_t;

  vec_t vecs[$];

  // driver: inputs change on the falling edge, pc sampled 1 ns after the rising edge
  task automatic drive(input logic rst, input logic [W-1:0] npc, input string tag);
    logic [W-1:0] exp;
    @(negedge clk);
    reset   = rst;
    next_pc = npc;
    exp_q.push_back(rst ? 32'h0000_0000 : npc);
    #2;
    check_eq({tag, "_hold"}, pc, prev_exp);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check_eq(tag, pc, exp);
    prev_exp = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      '{1'b0, 32'h0000_1000, "load_1000"},
      '{1'b0, 32'h0000_1004, "load_1004"},
      '{1'b0, 32'h0000_1008, "seq_1008"},
      '{1'b0, 32'h0000_100C, "seq_100c"},
      '{1'b0, 32'h0000_C000, "jump_c000"},
      '{1'b0, 32'h0000_C004, "jump_c004"},
      '{1'b1, 32'h0000_C004, "reset_mid"},
      '{1'b0, 32'h0000_2000, "resume_2000"},
      '{1'b1, 32'h0000_3000, "reset_held_1"},
      '{1'b1, 32'h0000_4000, "reset_held_2"},
      '{1'b0, 32'hFFFF_FFFF, "all_ones"},
      '{1'b0, 32'h0000_0002, "unaligned_2"},
      '{1'b0, 32'h0000_0002, "stall_2"},
      '{1'b0, 32'hFFFF_FFFC, "top_word"},
      '{1'b0, 32'hA5A5_5A5A, "pattern"}
    };

    // reset wins over next_pc on the very first edge
    reset   = 1'b1;
    next_pc = 32'h0000_1000;
    exp_q.push_back(32'h0000_0000);
    @(posedge clk);
    #1;
    prev_exp = exp_q.pop_front();
    check_eq("reset_first", pc, prev_exp);

    foreach (vecs[i]) drive(vecs[i].rst, vecs[i].npc, vecs[i].tag);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
